// File: rtl/mux2to1_arb.sv
// Round-robin arbiter for two byte requesters feeding a shared 2:1 mux,
// with a registered output byte delivered over a valid/ready handshake.
module mux2to1_arb #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req_i,
   input  logic [DATA_W-1:0] a_data_i,
   output logic              a_gnt_o,
   input  logic              b_req_i,
   input  logic [DATA_W-1:0] b_data_i,
   output logic              b_gnt_o,
   output logic              sel_o,
   output logic [DATA_W-1:0] y_o,
   output logic              y_valid_o,
   input  logic              y_ready_i
);

   typedef enum logic [1:0] {StIdle, StHoldA, StHoldB} state_e;

   state_e              r_state, w_state_nxt;
   logic                r_prio, w_prio_nxt;
   logic [DATA_W-1:0]   r_y, w_y_nxt;
   logic                w_valid;
   logic                w_load_ok;
   logic                w_a_gnt;
   logic                w_b_gnt;

   // Valid and select are decoded from the state so they can never disagree.
   assign w_valid   = (r_state != StIdle);
   assign w_load_ok = !w_valid || y_ready_i;

   assign w_a_gnt = !reset && w_load_ok && a_req_i && (!b_req_i || !r_prio);
   assign w_b_gnt = !reset && w_load_ok && b_req_i && (!a_req_i || r_prio);

   always_comb begin
      w_state_nxt = r_state;
      w_prio_nxt  = r_prio;
      w_y_nxt     = r_y;
      if (w_a_gnt) begin
         w_state_nxt = StHoldA;
         w_y_nxt     = a_data_i;
         w_prio_nxt  = 1'b1;
      end else if (w_b_gnt) begin
         w_state_nxt = StHoldB;
         w_y_nxt     = b_data_i;
         w_prio_nxt  = 1'b0;
      end else if (w_valid && y_ready_i) begin
         w_state_nxt = StIdle;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
         r_prio  <= 1'b0;
         r_y     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_prio  <= w_prio_nxt;
         r_y     <= w_y_nxt;
      end
   end

   assign a_gnt_o   = w_a_gnt;
   assign b_gnt_o   = w_b_gnt;
   assign y_o       = r_y;
   assign y_valid_o = w_valid;
   assign sel_o     = (r_state == StHoldA);

endmodule

// File: tb/tb_mux2to1_arb.sv
// Bench for mux2to1_arb: directed scenarios then random traffic, checked against
// a behavioural model of the arbitration rules plus an in-order delivery scoreboard.
module tb_mux2to1_arb;

   localparam int unsigned DATA_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              a_req_i, b_req_i, y_ready_i;
   logic [DATA_W-1:0] a_data_i, b_data_i;
   logic              a_gnt_o, b_gnt_o, sel_o, y_valid_o;
   logic [DATA_W-1:0] y_o;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state
   logic              m_valid = 1'b0;
   logic              m_sel   = 1'b0;
   logic              m_prio  = 1'b0;
   logic [DATA_W-1:0] m_y     = '0;
   logic [DATA_W-1:0] sb[$];
   logic              last_ga = 1'b0;
   logic              last_gb = 1'b0;

   mux2to1_arb #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .a_req_i   (a_req_i),
      .a_data_i  (a_data_i),
      .a_gnt_o   (a_gnt_o),
      .b_req_i   (b_req_i),
      .b_data_i  (b_data_i),
      .b_gnt_o   (b_gnt_o),
      .sel_o     (sel_o),
      .y_o       (y_o),
      .y_valid_o (y_valid_o),
      .y_ready_i (y_ready_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                        input logic [DATA_W-1:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: check grants before the edge, advance the model, check registers after.
   task automatic cycle();
      logic ga, gb, load_ok;
      @(negedge clk);
      load_ok = !m_valid || y_ready_i;
      ga = 1'b0;
      gb = 1'b0;
      if (!reset && load_ok) begin
         if (a_req_i && b_req_i) begin
            if (m_prio) gb = 1'b1;
            else        ga = 1'b1;
         end else begin
            ga = a_req_i;
            gb = b_req_i;
         end
      end
      check("a_gnt", {7'b0, a_gnt_o}, {7'b0, ga});
      check("b_gnt", {7'b0, b_gnt_o}, {7'b0, gb});
      if (reset) begin
         m_valid = 1'b0; m_sel = 1'b0; m_prio = 1'b0; m_y = '0;
         sb.delete();
      end else begin
         if (m_valid && y_ready_i && sb.size() != 0) check("delivered", y_o, sb.pop_front());
         if (ga) begin
            m_y = a_data_i; m_valid = 1'b1; m_sel = 1'b1; m_prio = 1'b1;
            sb.push_back(a_data_i);
         end else if (gb) begin
            m_y = b_data_i; m_valid = 1'b1; m_sel = 1'b0; m_prio = 1'b0;
            sb.push_back(b_data_i);
         end else if (m_valid && y_ready_i) begin
            m_valid = 1'b0; m_sel = 1'b0;
         end
      end
      last_ga = ga;
      last_gb = gb;
      @(posedge clk);
      #1;
      check("y_valid", {7'b0, y_valid_o}, {7'b0, m_valid});
      check("sel", {7'b0, sel_o}, {7'b0, m_sel});
      check("y", y_o, m_y);
   endtask

   initial begin
      reset = 1'b1; a_req_i = 1'b1; a_data_i = 8'hAA; b_req_i = 1'b0; b_data_i = 8'h55;
      y_ready_i = 1'b1;

      // Reset held with A requesting
      cycle(); cycle();
      check("rst_y", y_o, 8'h00);
      check("rst_valid", {7'b0, y_valid_o}, 8'h00);

      // Single requesters
      reset = 1'b0;
      cycle();
      check("single_a_y", y_o, 8'hAA);
      check("single_a_sel", {7'b0, sel_o}, 8'h01);
      a_req_i = 1'b0;
      b_req_i = 1'b1;
      cycle();
      check("single_b_y", y_o, 8'h55);
      check("single_b_sel", {7'b0, sel_o}, 8'h00);
      b_req_i = 1'b0;

      // Drain to idle
      cycle();
      check("drain_valid", {7'b0, y_valid_o}, 8'h00);
      check("drain_y_kept", y_o, 8'h55);

      // Contention: strict alternation, no bubbles
      a_req_i = 1'b1; b_req_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("contend_y", y_o, (i % 2 == 0) ? 8'hAA : 8'h55);
         check("contend_valid", {7'b0, y_valid_o}, 8'h01);
      end

      // Backpressure, then release with drain and A load on one edge
      y_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      check("bp_y", y_o, 8'h55);
      y_ready_i = 1'b1;
      cycle();
      check("bp_release_y", y_o, 8'hAA);
      check("bp_release_valid", {7'b0, y_valid_o}, 8'h01);

      // Reset mid-operation while B is favoured
      y_ready_i = 1'b0;
      reset = 1'b1;
      cycle();
      check("midrst_valid", {7'b0, y_valid_o}, 8'h00);
      reset = 1'b0;
      y_ready_i = 1'b1;
      cycle();
      check("midrst_a_first", y_o, 8'hAA);
      check("midrst_sel", {7'b0, sel_o}, 8'h01);
      a_req_i = 1'b0; b_req_i = 1'b0;
      cycle();

      // Random traffic; requesters hold req/data until granted
      for (int i = 0; i < 400; i++) begin
         reset     = ($urandom_range(0, 59) == 0);
         y_ready_i = ($urandom_range(0, 3) != 0);
         if (!a_req_i || last_ga) begin
            a_req_i  = $urandom_range(0, 1) == 1;
            a_data_i = DATA_W'($urandom);
         end
         if (!b_req_i || last_gb) begin
            b_req_i  = $urandom_range(0, 1) == 1;
            b_data_i = DATA_W'($urandom);
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
